// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and bus constants shared by the GPIO port and
// any peripheral that reuses its input synchroniser.
package gpio_pkg;

  // Peripheral bus data width in bits.
  localparam int BUS_W = 16;

  // Largest pin count that fits a single bus word.
  localparam int MAX_PINS = BUS_W;

  // Synchroniser depth limits. Two flops is the practical minimum for
  // metastability settling; beyond four only adds latency.
  localparam int MIN_SYNC = 2;
  localparam int MAX_SYNC = 4;

  // Register offsets, decoded from addr[3:0].
  localparam logic [3:0] GPIO_OUT     = 4'h0;
  localparam logic [3:0] GPIO_DIR     = 4'h2;
  localparam logic [3:0] GPIO_IN      = 4'h4;
  localparam logic [3:0] GPIO_SET     = 4'h6;
  localparam logic [3:0] GPIO_CLR     = 4'h8;
  localparam logic [3:0] GPIO_RISE_EN = 4'hA;
  localparam logic [3:0] GPIO_FALL_EN = 4'hC;
  localparam logic [3:0] GPIO_STATUS  = 4'hE;

  typedef logic [BUS_W-1:0] bus_t;

  // True for offsets that actually hold a register; anything else reads 0
  // and ignores writes.
  function automatic logic is_mapped(input logic [3:0] offs);
    return (offs == GPIO_OUT)     || (offs == GPIO_DIR)     ||
           (offs == GPIO_IN)      || (offs == GPIO_SET)     ||
           (offs == GPIO_CLR)     || (offs == GPIO_RISE_EN) ||
           (offs == GPIO_FALL_EN) || (offs == GPIO_STATUS);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-flop synchroniser for asynchronous inputs. Every stage
// resets to 0, so downstream edge logic sees a known level after reset.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < MIN_SYNC || STAGES > MAX_SYNC) begin : g_bad_stages
    $error("gpio_sync: STAGES must be in 2..4");
  end

  if (WIDTH < 1) begin : g_bad_width
    $error("gpio_sync: WIDTH must be at least 1");
  end

  // Stage 0 samples the raw pins; the last stage is the clean output.
  logic [STAGES-1:0][WIDTH-1:0] chain;

  // Shift the chain by one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: parametrised GPIO port on the 16-bit peripheral bus.
// Holds the register file, edge detection, W1C interrupt status and the
// combinational read mux; input synchronisation lives in gpio_sync.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  input  logic             we,
  output logic [15:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_dir,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > MAX_PINS) begin : g_bad_width
    $error("gpio_irq: WIDTH must be in 1..16");
  end

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic [3:0]       offs;
  logic [WIDTH-1:0] wd;

  assign offs = addr[3:0];
  assign wd   = wdata[WIDTH-1:0];

  // Only addr[3:0] and the low WIDTH bits of wdata carry meaning.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{addr[15:4], wdata};

  logic wr_out;
  logic wr_dir;
  logic wr_set;
  logic wr_clr;
  logic wr_rise;
  logic wr_fall;
  logic wr_stat;

  assign wr_out  = we && (offs == GPIO_OUT);
  assign wr_dir  = we && (offs == GPIO_DIR);
  assign wr_set  = we && (offs == GPIO_SET);
  assign wr_clr  = we && (offs == GPIO_CLR);
  assign wr_rise = we && (offs == GPIO_RISE_EN);
  assign wr_fall = we && (offs == GPIO_FALL_EN);
  assign wr_stat = we && (offs == GPIO_STATUS);

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;

  // Output data: plain write, or atomic OR / AND-NOT so software never
  // needs a read-modify-write that could race another context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (wr_out) begin
      out_q <= wd;
    end else if (wr_set) begin
      out_q <= out_q | wd;
    end else if (wr_clr) begin
      out_q <= out_q & ~wd;
    end
  end

  // Pin direction, 1 = drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= '0;
    end else if (wr_dir) begin
      dir_q <= wd;
    end
  end

  // Per-pin edge enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else begin
      if (wr_rise) begin
        rise_en_q <= wd;
      end
      if (wr_fall) begin
        fall_en_q <= wd;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Input path and edge detection
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] in_prev;

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpio_in),
    .q     (in_s)
  );

  // One extra flop behind the synchroniser gives the previous level for
  // edge comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_prev <= '0;
    end else begin
      in_prev <= in_s;
    end
  end

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] w1c_vec;

  // Edges are seen regardless of direction, so looped-back outputs also
  // raise events.
  assign rise    = in_s & ~in_prev;
  assign fall    = ~in_s & in_prev;
  assign set_vec = (rise & rise_en_q) | (fall & fall_en_q);
  assign w1c_vec = wr_stat ? wd : '0;

  // Sticky status: a fresh edge wins over a W1C on the same clock so an
  // event arriving during the acknowledge is never lost. Clearing an
  // enable leaves already-pending bits alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~w1c_vec) | set_vec;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs and read mux
  // ---------------------------------------------------------------------
  assign gpio_out = out_q;
  assign gpio_dir = dir_q;
  assign irq      = |status_q;

  // Zero-latency read; SET/CLR and unmapped offsets return 0.
  always_comb begin
    rdata = '0;
    case (offs)
      GPIO_OUT:     rdata[WIDTH-1:0] = out_q;
      GPIO_DIR:     rdata[WIDTH-1:0] = dir_q;
      GPIO_IN:      rdata[WIDTH-1:0] = in_s;
      GPIO_RISE_EN: rdata[WIDTH-1:0] = rise_en_q;
      GPIO_FALL_EN: rdata[WIDTH-1:0] = fall_en_q;
      GPIO_STATUS:  rdata[WIDTH-1:0] = status_q;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: self-checking bench for gpio_irq. dut0 (8 pins, 2 stages)
// is tracked by a behavioural model; dut1 (16/3) and dut2 (4/2) cover the
// parameter corners with fixed expectations.
module tb_gpio_irq;

  localparam int S0 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] addr0 = '0, wdata0 = '0, rdata0;
  logic        we0 = 1'b0, irq0;
  logic [7:0]  gi0 = '0, go0, gd0;

  logic [15:0] addr1 = '0, wdata1 = '0, rdata1;
  logic        we1 = 1'b0, irq1;
  logic [15:0] gi1 = '0, go1, gd1;

  logic [15:0] addr2 = '0, wdata2 = '0, rdata2;
  logic        we2 = 1'b0, irq2;
  logic [3:0]  gi2 = '0, go2, gd2;

  gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr0), .wdata(wdata0), .we(we0),
    .rdata(rdata0), .gpio_in(gi0), .gpio_out(go0), .gpio_dir(gd0), .irq(irq0));

  gpio_irq #(.WIDTH(16), .SYNC_STAGES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr(addr1), .wdata(wdata1), .we(we1),
    .rdata(rdata1), .gpio_in(gi1), .gpio_out(go1), .gpio_dir(gd1), .irq(irq1));

  gpio_irq #(.WIDTH(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .addr(addr2), .wdata(wdata2), .we(we2),
    .rdata(rdata2), .gpio_in(gi2), .gpio_out(go2), .gpio_dir(gd2), .irq(irq2));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model for dut0. m_hist[0] is the pin value sampled at the
  // most recent edge; a sample reaches IN after S0 edges.
  logic [7:0] m_out, m_dir, m_rise, m_fall, m_status;
  logic [7:0] m_hist[$];

  function automatic void m_reset();
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
    m_hist.delete();
    for (int i = 0; i <= S0; i++) m_hist.push_back(8'h00);
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    case (a[3:0])
      4'h0: return {8'h00, m_out};
      4'h2: return {8'h00, m_dir};
      4'h4: return {8'h00, m_hist[S0-1]};
      4'hA: return {8'h00, m_rise};
      4'hC: return {8'h00, m_fall};
      4'hE: return {8'h00, m_status};
      default: return 16'h0000;
    endcase
  endfunction

  // One clock for all DUTs; the model consumes dut0's bus/pins at the edge.
  task automatic tick();
    logic [7:0] ins, prv, setv, w1c;
    @(posedge clk);
    if (rst_n) begin
      ins  = m_hist[S0-1];
      prv  = m_hist[S0];
      setv = (ins & ~prv & m_rise) | (~ins & prv & m_fall);
      w1c  = 8'h00;
      if (we0) begin
        case (addr0[3:0])
          4'h0: m_out = wdata0[7:0];
          4'h2: m_dir = wdata0[7:0];
          4'h6: m_out = m_out | wdata0[7:0];
          4'h8: m_out = m_out & ~wdata0[7:0];
          4'hA: m_rise = wdata0[7:0];
          4'hC: m_fall = wdata0[7:0];
          4'hE: w1c = wdata0[7:0];
          default: ;
        endcase
      end
      m_status = (m_status & ~w1c) | setv;
      m_hist.push_front(gi0);
      void'(m_hist.pop_back());
    end
    #1;
    we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr0(input logic [15:0] a, input logic [15:0] d);
    addr0 = a; wdata0 = d; we0 = 1'b1; tick();
  endtask
  task automatic wr1(input logic [15:0] a, input logic [15:0] d);
    addr1 = a; wdata1 = d; we1 = 1'b1; tick();
  endtask
  task automatic wr2(input logic [15:0] a, input logic [15:0] d);
    addr2 = a; wdata2 = d; we2 = 1'b1; tick();
  endtask

  task automatic rd0(input logic [15:0] a, output logic [15:0] d);
    addr0 = a; #1; d = rdata0;
  endtask
  task automatic rd1(input logic [15:0] a, output logic [15:0] d);
    addr1 = a; #1; d = rdata1;
  endtask
  task automatic rd2(input logic [15:0] a, output logic [15:0] d);
    addr2 = a; #1; d = rdata2;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    gi0 = 8'hFF;
    #2 rst_n = 1'b0;
    m_reset();
    ticks(3);
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq0); end
    n_checks++; if (go0 !== 8'h00) begin n_fail++; $display("FAIL rst_out_pin: got %h want 00", go0); end
    for (int a = 0; a < 16; a += 2) begin
      rd0(16'(a), d);
      n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_reg_%0h: got %h want 0000", a, d); end
    end
    rst_n = 1'b1;
    tick();
    rd0(16'h4, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_in_1cyc: got %h want 0000", d); end
    tick();
    rd0(16'h4, d);
    n_checks++; if (d !== 16'h00FF) begin n_fail++; $display("FAIL rst_in_2cyc: got %h want 00ff", d); end
    ticks(2);
    rd0(16'hE, d);
    n_checks++; if (d !== 16'h0000 || irq0 !== 1'b0) begin n_fail++; $display("FAIL rst_no_status: got %h/%b want 0000/0", d, irq0); end
  endtask

  task automatic test_out_set_clr();
    logic [15:0] d;
    wr0(16'h0, 16'h000F);
    n_checks++; if (go0 !== 8'h0F) begin n_fail++; $display("FAIL osc_out: got %h want 0f", go0); end
    wr0(16'h6, 16'h00A0);
    n_checks++; if (go0 !== 8'hAF) begin n_fail++; $display("FAIL osc_set: got %h want af", go0); end
    wr0(16'h8, 16'h0005);
    n_checks++; if (go0 !== 8'hAA) begin n_fail++; $display("FAIL osc_clr: got %h want aa", go0); end
    rd0(16'h0, d);
    n_checks++; if (d !== 16'h00AA) begin n_fail++; $display("FAIL osc_rd_out: got %h want 00aa", d); end
    rd0(16'h6, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL osc_rd_set: got %h want 0000", d); end
    rd0(16'h8, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL osc_rd_clr: got %h want 0000", d); end
    wr0(16'h2, 16'hFF3C);
    n_checks++; if (gd0 !== 8'h3C) begin n_fail++; $display("FAIL osc_dir: got %h want 3c", gd0); end
  endtask

  task automatic test_rise();
    logic [15:0] d;
    gi0 = 8'h00; ticks(4);
    wr0(16'hA, 16'h0001);
    wr0(16'hC, 16'h0000);
    wr0(16'hE, 16'h00FF);
    gi0 = 8'h01;
    tick();
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL rise_c1: got %b want 0", irq0); end
    tick();
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL rise_c2: got %b want 0", irq0); end
    tick();
    rd0(16'hE, d);
    n_checks++; if (irq0 !== 1'b1 || d !== 16'h0001) begin n_fail++; $display("FAIL rise_c3: got %b/%h want 1/0001", irq0, d); end
    wr0(16'hE, 16'h0001);
    gi0 = 8'h00; ticks(4);
    rd0(16'hE, d);
    n_checks++; if (d !== 16'h0000 || irq0 !== 1'b0) begin n_fail++; $display("FAIL rise_nofall: got %h/%b want 0000/0", d, irq0); end
  endtask

  task automatic test_fall_w1c();
    logic [15:0] d;
    wr0(16'hA, 16'h0000);
    wr0(16'hC, 16'h0080);
    gi0 = 8'h80; ticks(4);
    wr0(16'hE, 16'h00FF);
    gi0 = 8'h00; ticks(3);
    rd0(16'hE, d);
    n_checks++; if (d !== 16'h0080 || irq0 !== 1'b1) begin n_fail++; $display("FAIL fall_set: got %h/%b want 0080/1", d, irq0); end
    wr0(16'hE, 16'h007F);
    rd0(16'hE, d);
    n_checks++; if (d !== 16'h0080 || irq0 !== 1'b1) begin n_fail++; $display("FAIL fall_w1c_0: got %h/%b want 0080/1", d, irq0); end
    wr0(16'hC, 16'h0000);
    rd0(16'hE, d);
    n_checks++; if (d !== 16'h0080) begin n_fail++; $display("FAIL fall_en_off_keeps: got %h want 0080", d); end
    wr0(16'hE, 16'h0080);
    rd0(16'hE, d);
    n_checks++; if (d !== 16'h0000 || irq0 !== 1'b0) begin n_fail++; $display("FAIL fall_w1c_1: got %h/%b want 0000/0", d, irq0); end
  endtask

  task automatic test_set_vs_clear();
    logic [15:0] d;
    gi0 = 8'h00;
    wr0(16'hA, 16'h0001);
    wr0(16'hC, 16'h0000);
    ticks(3);
    wr0(16'hE, 16'h00FF);
    gi0 = 8'h01;
    ticks(2);
    wr0(16'hE, 16'h0001);
    rd0(16'hE, d);
    n_checks++; if (d !== 16'h0001 || irq0 !== 1'b1) begin n_fail++; $display("FAIL setwins: got %h/%b want 0001/1", d, irq0); end
    wr0(16'hE, 16'h0001);
    rd0(16'hE, d);
    n_checks++; if (d !== 16'h0000 || irq0 !== 1'b0) begin n_fail++; $display("FAIL setwins_then_clr: got %h/%b want 0000/0", d, irq0); end
  endtask

  task automatic test_random();
    logic [15:0] d, a, e;
    for (int n = 0; n < 400; n++) begin
      a = 16'($urandom);
      rd0(a, d);
      e = m_read(a);
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL rnd_rd[%0d] a=%h: got %h want %h", n, a, d, e); end
      addr0  = 16'($urandom);
      if ($urandom_range(0, 3) != 0) addr0[3:0] = 4'(2 * $urandom_range(0, 7));
      wdata0 = 16'($urandom);
      we0    = ($urandom_range(0, 1) == 1);
      gi0    = gi0 ^ (8'($urandom) & 8'($urandom));
      tick();
      n_checks++;
      if (go0 !== m_out || gd0 !== m_dir || irq0 !== (|m_status)) begin
        n_fail++;
        $display("FAIL rnd_pins[%0d]: got out=%h dir=%h irq=%b want out=%h dir=%h irq=%b",
                 n, go0, gd0, irq0, m_out, m_dir, |m_status);
      end
    end
  endtask

  task automatic test_wide();
    logic [15:0] d;
    wr1(16'h0, 16'h0000);
    wr1(16'h6, 16'hFFFF);
    n_checks++; if (go1 !== 16'hFFFF) begin n_fail++; $display("FAIL wide_set: got %h want ffff", go1); end
    wr1(16'h8, 16'h8001);
    n_checks++; if (go1 !== 16'h7FFE) begin n_fail++; $display("FAIL wide_clr: got %h want 7ffe", go1); end
    wr1(16'hA, 16'h8000);
    gi1 = 16'h8000;
    ticks(3);
    n_checks++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL wide_irq_c3: got %b want 0", irq1); end
    tick();
    rd1(16'hE, d);
    n_checks++; if (irq1 !== 1'b1 || d !== 16'h8000) begin n_fail++; $display("FAIL wide_irq_c4: got %b/%h want 1/8000", irq1, d); end
  endtask

  task automatic test_narrow();
    logic [15:0] d;
    wr2(16'h0, 16'hFFFF);
    wr2(16'h2, 16'hFFFA);
    gi2 = 4'hF;
    ticks(3);
    rd2(16'h0, d);
    n_checks++; if (d !== 16'h000F || go2 !== 4'hF) begin n_fail++; $display("FAIL narrow_out: got %h/%h want 000f/f", d, go2); end
    rd2(16'h2, d);
    n_checks++; if (d !== 16'h000A || gd2 !== 4'hA) begin n_fail++; $display("FAIL narrow_dir: got %h/%h want 000a/a", d, gd2); end
    rd2(16'h4, d);
    n_checks++; if (d !== 16'h000F) begin n_fail++; $display("FAIL narrow_in: got %h want 000f", d); end
  endtask

  task automatic test_reset_midop();
    logic [15:0] d;
    wr0(16'h6, 16'h0055);
    wr0(16'hA, 16'h00FF);
    gi0 = ~m_hist[0];
    ticks(3);
    n_checks++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_irq: got %b want 1", irq0); end
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    rd0(16'hE, d);
    n_checks++; if (irq0 !== 1'b0 || go0 !== 8'h00 || d !== 16'h0000) begin n_fail++; $display("FAIL midrst: got irq=%b out=%h st=%h want 0/00/0000", irq0, go0, d); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_out_set_clr();
    test_rise();
    test_fall_w1c();
    test_set_vs_clear();
    test_random();
    test_wide();
    test_narrow();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
